// File: rtl/bipi_pkg.sv
// rtl/bipi_pkg.sv - shared BIP I control-field encodings and width defaults
// Imported by the datapath and the control decoder so both agree on strobe meanings.
package bipi_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 11;
   localparam int RAM_DEPTH_DEF  = 2048;

   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_ALU = 2'b10;

   localparam logic SEL_B_MEM = 1'b0;
   localparam logic SEL_B_IMM = 1'b1;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - data RAM with synchronous write and gated asynchronous read
// Addresses at or beyond RAM_DEPTH read as zero and ignore writes.
module data_memory
   import bipi_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int RAM_DEPTH  = RAM_DEPTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
   logic                  in_range;

   assign in_range = (32'(addr_i) < 32'(RAM_DEPTH));

   always_ff @(posedge clk_i) begin
      if (we_i && in_range) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read sees the pre-edge word, so a same-cycle write is visible only next cycle.
   assign rdata_o = (re_i && in_range) ? mem_q[addr_i] : '0;

endmodule

// File: rtl/datapath_bipi.sv
// rtl/datapath_bipi.sv - BIP I accumulator datapath: muxes, add/sub ALU, accumulator, data RAM
// Optional signed-overflow flag register enabled by BIPI_DATAPATH_OVF_EN.
module datapath_bipi
   import bipi_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int RAM_DEPTH  = RAM_DEPTH_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            SelA,
   input  logic                  SelB,
   input  logic                  WrAcc,
   input  logic                  Op,
   input  logic                  WrRam,
   input  logic                  RdRam,
   input  logic [ADDR_WIDTH-1:0] Operand,
   output logic [DATA_WIDTH-1:0] Acc,
   output logic                  Ovf
);

   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] imm, mem_data, alu_b, alu_out;
   logic                  ram_we;

   assign imm = {{(DATA_WIDTH-ADDR_WIDTH){Operand[ADDR_WIDTH-1]}}, Operand};

   // A store issued in the reset cycle must not reach the RAM.
   assign ram_we = WrRam && !Reset;

   data_memory #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RAM_DEPTH (RAM_DEPTH)
   ) u_data_memory (
      .clk_i  (Clk),
      .we_i   (ram_we),
      .re_i   (RdRam),
      .addr_i (Operand),
      .wdata_i(acc_q),
      .rdata_o(mem_data)
   );

   assign alu_b   = (SelB == SEL_B_IMM) ? imm : mem_data;
   assign alu_out = (Op == OP_SUB) ? (acc_q - alu_b) : (acc_q + alu_b);

   always_comb begin
      acc_d = acc_q;
      if (WrAcc) begin
         case (SelA)
            SEL_A_MEM: acc_d = mem_data;
            SEL_A_IMM: acc_d = imm;
            SEL_A_ALU: acc_d = alu_out;
            default:   acc_d = acc_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign Acc = acc_q;

`ifdef BIPI_DATAPATH_OVF_EN
   logic ovf_q, ovf_d;
   logic sign_a, sign_b, sign_r;

   assign sign_a = acc_q[DATA_WIDTH-1];
   assign sign_b = alu_b[DATA_WIDTH-1];
   assign sign_r = alu_out[DATA_WIDTH-1];

   always_comb begin
      ovf_d = ovf_q;
      if (WrAcc && (SelA == SEL_A_ALU)) begin
         if (Op == OP_SUB) begin
            ovf_d = (sign_a != sign_b) && (sign_r != sign_a);
         end else begin
            ovf_d = (sign_a == sign_b) && (sign_r != sign_a);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign Ovf = ovf_q;
`else
   assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_bipi.sv
// tb/tb_datapath_bipi.sv - table-driven bench for datapath_bipi
// Expected Ovf values are masked to zero unless BIPI_DATAPATH_OVF_EN is defined.
module tb_datapath_bipi;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  SelA;
   logic        SelB, WrAcc, Op, WrRam, RdRam;
   logic [10:0] Operand;
   logic [15:0] Acc;
   logic        Ovf;

   int total = 0;
   int bad   = 0;

`ifdef BIPI_DATAPATH_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [1:0]  sel_a;
      logic        sel_b;
      logic        wr_acc;
      logic        op;
      logic        wr_ram;
      logic        rd_ram;
      logic [10:0] operand;
      logic [15:0] acc;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   datapath_bipi dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .SelA   (SelA),
      .SelB   (SelB),
      .WrAcc  (WrAcc),
      .Op     (Op),
      .WrRam  (WrRam),
      .RdRam  (RdRam),
      .Operand(Operand),
      .Acc    (Acc),
      .Ovf    (Ovf)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t v(logic rst, logic [1:0] sa, logic sb, logic wa, logic op,
                              logic wr, logic rd, logic [10:0] opd, logic [15:0] acc, logic ovf);
      vec_t r;
      r.rst = rst; r.sel_a = sa; r.sel_b = sb; r.wr_acc = wa; r.op = op;
      r.wr_ram = wr; r.rd_ram = rd; r.operand = opd; r.acc = acc; r.ovf = ovf & OVF_EN;
      return r;
   endfunction

   task automatic drive(input vec_t x);
      Reset = x.rst; SelA = x.sel_a; SelB = x.sel_b; WrAcc = x.wr_acc; Op = x.op;
      WrRam = x.wr_ram; RdRam = x.rd_ram; Operand = x.operand;
   endtask

   task automatic check(input string name, input logic [15:0] exp_acc, input logic exp_ovf);
      total++;
      if (Acc !== exp_acc) begin
         bad++;
         $display("FAIL %s acc: got %h want %h", name, Acc, exp_acc);
      end
      total++;
      if (Ovf !== exp_ovf) begin
         bad++;
         $display("FAIL %s ovf: got %b want %b", name, Ovf, exp_ovf);
      end
   endtask

   task automatic step(input vec_t x, input string name);
      @(negedge Clk);
      drive(x);
      @(posedge Clk);
      #1;
      check(name, x.acc, x.ovf);
   endtask

   initial begin
      //         rst sa     sb wa op wr rd operand  acc       ovf
      vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 0, 11'h000, 16'h0000, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h005, 16'h0005, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h7FF, 16'hFFFF, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h3FF, 16'h03FF, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h3FF, 16'h07FE, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h3FF, 16'h0BFD, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h3FF, 16'h0FFC, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h238, 16'h1234, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h010, 16'h1234, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h000, 16'h0000, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 0, 1, 11'h010, 16'h1234, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 0, 0, 11'h010, 16'h0000, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h7FF, 16'hFFFF, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h001, 16'h0000, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 1, 0, 1, 11'h010, 16'hEDCC, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h0AA, 16'h00AA, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 1, 0, 11'h020, 16'h0020, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 0, 1, 11'h020, 16'h00AA, 0));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h055, 16'h0055, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 1, 1, 11'h020, 16'h00AA, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 0, 1, 11'h020, 16'h0055, 0));
      // doubling chain through RAM[0x040] to build 0x7FFF
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h3FF, 16'h03FF, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h040, 16'h03FF, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h040, 16'h07FE, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h040, 16'h07FE, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h040, 16'h0FFC, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h040, 16'h0FFC, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h040, 16'h1FF8, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h040, 16'h1FF8, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h040, 16'h3FF0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h040, 16'h3FF0, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h040, 16'h7FE0, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h01F, 16'h7FFF, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h050, 16'h7FFF, 0));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h001, 16'h8000, 1));
      vecs.push_back(v(0, 2'b10, 1, 1, 1, 0, 0, 11'h001, 16'h7FFF, 1));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h001, 16'h8000, 1));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h001, 16'h0001, 1));
      vecs.push_back(v(0, 2'b10, 1, 1, 0, 0, 0, 11'h001, 16'h0002, 0));
      vecs.push_back(v(0, 2'b10, 0, 1, 0, 0, 1, 11'h050, 16'h8001, 1));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 1, 0, 11'h030, 16'h8001, 1));
      vecs.push_back(v(0, 2'b01, 0, 1, 0, 0, 0, 11'h155, 16'h0155, 1));
      vecs.push_back(v(1, 2'b01, 0, 1, 0, 1, 0, 11'h030, 16'h0000, 0));
      vecs.push_back(v(0, 2'b00, 0, 1, 0, 0, 1, 11'h030, 16'h8001, 0));
      vecs.push_back(v(0, 2'b11, 1, 1, 1, 0, 1, 11'h030, 16'h8001, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 11'h000, 16'h8001, 0));

      foreach (vecs[i]) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset held for two cycles with live strobes: Acc stays 0, RAM[0x020] keeps 0x0055.
      step(v(1, 2'b10, 1, 1, 0, 1, 1, 11'h020, 16'h0000, 0), "rst_hold0");
      step(v(1, 2'b01, 1, 1, 1, 1, 0, 11'h020, 16'h0000, 0), "rst_hold1");
      step(v(0, 2'b00, 0, 1, 0, 0, 1, 11'h020, 16'h0055, 0), "post_rst_read");
      step(v(0, 2'b10, 1, 1, 1, 0, 0, 11'h005, 16'h0050, 0), "post_rst_sub");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
